// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the data-side memory responder: MMIO map,
// STATUS bit layout and the access-target decode type.
package data_mem_pkg;

  localparam logic [15:0] MMIO_BASE      = 16'hFFFF;

  localparam logic [15:0] OFF_CONSOLE_TX = 16'h0000;
  localparam logic [15:0] OFF_STATUS     = 16'h0004;
  localparam logic [15:0] OFF_CYCLES     = 16'h0008;
  localparam logic [15:0] OFF_FAULT_ADDR = 16'h000C;

  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 4;
  localparam int ST_CNT_W     = 4;

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_RAM,
    TGT_TX,
    TGT_STATUS,
    TGT_CYCLES,
    TGT_FAULT_ADDR
  } target_e;

  function automatic logic [31:0] status_word(input logic full,
                                              input logic empty,
                                              input logic ovf,
                                              input logic [ST_CNT_W-1:0] cnt);
    logic [31:0] w;
    w                             = '0;
    w[ST_FULL_BIT]                = full;
    w[ST_EMPTY_BIT]               = empty;
    w[ST_OVF_BIT]                 = ovf;
    w[ST_CNT_LSB +: ST_CNT_W]     = cnt;
    return w;
  endfunction

endpackage

// File: rtl/data_mem_responder_console_fifo.sv
// Console byte FIFO: head is combinational (0 when empty), push/pop commit at the edge.
// Push while full with no pop is dropped and flagged on drop_o; push+pop when full both occur.
module console_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [7:0]          push_dat_i,
  input  logic                pop_i,
  output logic [7:0]          head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] count_o,
  output logic                drop_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            buf_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A pop frees the slot in the same edge, so a full FIFO still accepts a push then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;

  // Storage is not reset; masking the head keeps the output defined after reset.
  assign head_o  = empty_o ? 8'h00 : buf_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) buf_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-port responder: word RAM, console FIFO, cycle counter, sticky fault; loads are
// combinational (0-cycle), stores commit at the edge; console output is valid/ready.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_LOG2      = 10,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  output logic [31:0] mem_read_data,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic        fault
);

  localparam logic [32:0] RAM_BYTES = 33'd4 << DEPTH_LOG2;

  logic [31:0]           ram_q [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] ram_idx;

  target_e               target;
  logic                  req, bad, wr_ok;

  logic [31:0]           cyc_q, cyc_d;
  logic                  ovf_q, ovf_d;
  logic                  fault_q, fault_d;
  logic [31:0]           fault_addr_q, fault_addr_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic [ST_CNT_W-1:0]   status_cnt;
  logic [31:0]           status_val;

  // Misalignment overrides any region match, so every bad access lands on TGT_NONE.
  always_comb begin
    target = TGT_NONE;
    if (data_addr[31:16] == MMIO_BASE) begin
      case (data_addr[15:0])
        OFF_CONSOLE_TX: target = TGT_TX;
        OFF_STATUS:     target = TGT_STATUS;
        OFF_CYCLES:     target = TGT_CYCLES;
        OFF_FAULT_ADDR: target = TGT_FAULT_ADDR;
        default:        target = TGT_NONE;
      endcase
    end else if ({1'b0, data_addr} < RAM_BYTES) begin
      target = TGT_RAM;
    end
    if (data_addr[1:0] != 2'b00) target = TGT_NONE;
  end

  assign ram_idx = data_addr[DEPTH_LOG2+1:2];
  assign req     = mem_read_en || mem_write_en;
  assign bad     = req && (target == TGT_NONE);
  assign wr_ok   = mem_write_en && (target != TGT_NONE);

  assign fifo_push = wr_ok && (target == TGT_TX);
  assign fifo_pop  = console_valid && console_ready;

  console_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_console_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (fifo_push),
    .push_dat_i (mem_write_data[7:0]),
    .pop_i      (fifo_pop),
    .head_o     (console_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .drop_o     (fifo_drop)
  );

  assign console_valid = !fifo_empty;
  assign fault         = fault_q;
  assign status_cnt    = ST_CNT_W'(fifo_count);
  assign status_val    = status_word(fifo_full, fifo_empty, ovf_q, status_cnt);

  always_comb begin
    mem_read_data = '0;
    if (mem_read_en) begin
      case (target)
        TGT_RAM:        mem_read_data = ram_q[ram_idx];
        TGT_STATUS:     mem_read_data = status_val;
        TGT_CYCLES:     mem_read_data = cyc_q;
        TGT_FAULT_ADDR: mem_read_data = fault_addr_q;
        default:        mem_read_data = '0;
      endcase
    end
  end

  always_comb begin
    cyc_d        = cyc_q + 32'd1;
    ovf_d        = ovf_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (wr_ok) begin
      case (target)
        TGT_CYCLES:     cyc_d = mem_write_data;
        TGT_STATUS:     if (mem_write_data[ST_OVF_BIT]) ovf_d = 1'b0;
        TGT_FAULT_ADDR: begin
          fault_d      = 1'b0;
          fault_addr_d = '0;
        end
        default: ;
      endcase
    end
    if (fifo_drop) ovf_d = 1'b1;
    // Only the first fault since the last clear is recorded.
    if (bad) begin
      fault_d = 1'b1;
      if (!fault_q) fault_addr_d = data_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q        <= '0;
      ovf_q        <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      cyc_q        <= cyc_d;
      ovf_q        <= ovf_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok && (target == TGT_RAM)) ram_q[ram_idx] <= mem_write_data;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with an expected-value queue scoreboard.
module tb_data_mem_responder;

  localparam logic [31:0] A_TX     = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC    = 32'hFFFF_0008;
  localparam logic [31:0] A_FADDR  = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr, mem_write_data, mem_read_data;
  logic        mem_read_en, mem_write_en;
  logic [7:0]  console_data;
  logic        console_valid, console_ready, fault;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  con_q[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(10), .FIFO_DEPTH_LOG2(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_addr      (data_addr),
    .mem_write_data (mem_write_data),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data),
    .console_data   (console_data),
    .console_valid  (console_valid),
    .console_ready  (console_ready),
    .fault          (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    data_addr      = '0;
    mem_write_data = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic sig(input string tag, input logic [31:0] obs, input logic [31:0] e);
    exp_q.push_back(e);
    chk(tag, obs);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    idle();
    data_addr      = a;
    mem_write_data = d;
    mem_write_en   = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    idle();
    data_addr   = a;
    mem_read_en = 1'b1;
    exp_q.push_back(e);
    #1;
    chk(tag, mem_read_data);
    tick();
    idle();
  endtask

  task automatic tx(input logic [7:0] b);
    if (con_q.size() < 8) con_q.push_back(b);
    wr(A_TX, {24'h0, b});
  endtask

  task automatic pop_chk(input string tag);
    console_ready = 1'b1;
    #1;
    sig({tag, "_valid"}, {31'h0, console_valid}, 32'h1);
    if (con_q.size() != 0) sig({tag, "_data"}, {24'h0, console_data}, {24'h0, con_q.pop_front()});
    tick();
    console_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    console_ready = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state and free-running counter
    sig("rst_valid", {31'h0, console_valid}, 32'h0);
    sig("rst_data",  {24'h0, console_data},  32'h0);
    sig("rst_fault", {31'h0, fault},         32'h0);
    rd("cyc_first", A_CYC, 32'd0);
    repeat (4) tick();
    rd("cyc_plus5", A_CYC, 32'd5);
    rd("fault_addr_rst", A_FADDR, 32'h0);
    wr(A_CYC, 32'hFFFF_FFFF);
    rd("cyc_loaded", A_CYC, 32'hFFFF_FFFF);
    rd("cyc_wrap", A_CYC, 32'h0);

    // RAM
    wr(32'h10, 32'hDEAD_BEEF);
    rd("ram_10", 32'h10, 32'hDEAD_BEEF);
    wr(32'h14, 32'h1234_5678);
    rd("ram_14", 32'h14, 32'h1234_5678);
    idle();
    data_addr = 32'h10; mem_write_data = 32'hCAFE_F00D;
    mem_read_en = 1'b1; mem_write_en = 1'b1;
    #1;
    sig("rw_pre_edge", mem_read_data, 32'hDEAD_BEEF);
    tick();
    idle();
    rd("rw_after", 32'h10, 32'hCAFE_F00D);
    rd("ram_14_kept", 32'h14, 32'h1234_5678);
    sig("ram_no_fault", {31'h0, fault}, 32'h0);

    // Console: overflow, OVF clear, in-order drain
    for (int i = 1; i <= 9; i++) tx(8'(i));
    rd("status_full_ovf", A_STATUS, 32'h8A);
    wr(A_STATUS, 32'h8);
    rd("status_ovf_clr", A_STATUS, 32'h82);
    for (int i = 0; i < 8; i++) pop_chk("drain");
    sig("drain_done", {31'h0, console_valid}, 32'h0);
    rd("status_empty", A_STATUS, 32'h04);

    // Full FIFO: simultaneous push and pop keeps count, no overflow
    for (int i = 0; i < 8; i++) tx(8'h40 + 8'(i));
    idle();
    data_addr = A_TX; mem_write_data = 32'h55; mem_write_en = 1'b1;
    console_ready = 1'b1;
    #1;
    sig("pp_head", {24'h0, console_data}, {24'h0, con_q.pop_front()});
    con_q.push_back(8'h55);
    tick();
    console_ready = 1'b0;
    idle();
    rd("status_pushpop", A_STATUS, 32'h82);
    for (int i = 0; i < 5; i++) pop_chk("part");
    rd("status_three", A_STATUS, 32'h30);

    // Faults
    rd("misaligned_rd", 32'h3, 32'h0);
    sig("fault_set", {31'h0, fault}, 32'h1);
    rd("fault_addr_1st", A_FADDR, 32'h3);
    rd("unmapped_rd", 32'h8000_0000, 32'h0);
    rd("fault_addr_kept", A_FADDR, 32'h3);
    rd("mmio_undef", 32'hFFFF_0010, 32'h0);
    wr(A_FADDR, 32'h0);
    sig("fault_clr", {31'h0, fault}, 32'h0);
    rd("fault_addr_clr", A_FADDR, 32'h0);
    wr(32'h12, 32'h1111_1111);
    sig("fault_wr", {31'h0, fault}, 32'h1);
    rd("fault_addr_wr", A_FADDR, 32'h12);
    rd("wr_suppressed", 32'h10, 32'hCAFE_F00D);

    // Mid-operation reset: FIFO flushed, store discarded, RAM kept
    idle();
    rst = 1'b1;
    data_addr = 32'h14; mem_write_data = 32'hBAD0_BAD0; mem_write_en = 1'b1;
    tick();
    idle();
    rst = 1'b0;
    con_q.delete();
    #1;
    sig("rst2_valid", {31'h0, console_valid}, 32'h0);
    sig("rst2_data",  {24'h0, console_data},  32'h0);
    sig("rst2_fault", {31'h0, fault},         32'h0);
    rd("rst2_status", A_STATUS, 32'h04);
    rd("rst2_faddr", A_FADDR, 32'h0);
    rd("rst2_ram10", 32'h10, 32'hCAFE_F00D);
    rd("rst2_ram14", 32'h14, 32'h1234_5678);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
